// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the program/data memory port arbiter.
package mem_arb_pkg;

  localparam int DEF_AW           = 8;
  localparam int DEF_DW           = 8;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int STARVE_W         = 4;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic {
    OWN_NORMAL = 1'b0,
    OWN_LOCKED = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU port, DBG port and memory-side signals around the arbiter.
// The arbiter uses the slave view; the core, loader and memory form the master side.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) ();

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_lock;
  logic          dbg_locked;

  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_locked,
    output mem_re, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_locked,
    input  mem_re, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive CPU wins while DBG is waiting; limit_hit_o
// tells the arbiter to let DBG through on the next contested cycle.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clock,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic limit_hit_o
);

  localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(LIMIT);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT_V)) begin
      cnt_d = cnt_q + STARVE_W'(1);
    end
  end

  // reset is active-low
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_hit_o = (cnt_q == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between the core FSM (CPU) and the debug/loader
// port (DBG): zero-latency grant, one-cycle read return, DBG lock and anti-starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  owner_e        owner_q, owner_d;
  logic          rdValid_q, rdValid_d;
  logic          rdOwner_q, rdOwner_d;
  logic          cpuGnt, dbgGnt;
  logic          starveHit;
  logic          cpuRvalid, dbgRvalid;
  logic          memRe, memWe;
  logic [AW-1:0] addrSel;
  logic [DW-1:0] wdataSel;

  mem_arb_starve_ctr #(
    .LIMIT       (STARVE_LIMIT)
  ) u_starve (
    .clock       (clock),
    .reset       (reset),
    .inc_i       (cpuGnt & bus.dbg_req),
    .clr_i       (dbgGnt | ~bus.dbg_req),
    .limit_hit_o (starveHit)
  );

  // reset is active-low; a pending read is dropped so nothing returns after release
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q   <= OWN_NORMAL;
      rdValid_q <= 1'b0;
      rdOwner_q <= PORT_CPU;
    end else begin
      owner_q   <= owner_d;
      rdValid_q <= rdValid_d;
      rdOwner_q <= rdOwner_d;
    end
  end

  always_comb begin
    owner_d = owner_q;
    case (owner_q)
      OWN_NORMAL: if (dbgGnt && bus.dbg_lock) owner_d = OWN_LOCKED;
      OWN_LOCKED: if (!bus.dbg_lock)          owner_d = OWN_NORMAL;
      default:                                owner_d = OWN_NORMAL;
    endcase
    rdValid_d = (cpuGnt && !bus.cpu_we) || (dbgGnt && !bus.dbg_we);
    rdOwner_d = dbgGnt ? PORT_DBG : PORT_CPU;
  end

  // CPU wins contention unless DBG has been starved up to the limit
  always_comb begin
    cpuGnt = 1'b0;
    dbgGnt = 1'b0;
    case (owner_q)
      OWN_LOCKED: dbgGnt = bus.dbg_req;
      default: begin
        dbgGnt = bus.dbg_req && (!bus.cpu_req || starveHit);
        cpuGnt = bus.cpu_req && !dbgGnt;
      end
    endcase
  end

  always_comb begin
    memRe    = 1'b0;
    memWe    = 1'b0;
    addrSel  = '0;
    wdataSel = '0;
    if (cpuGnt) begin
      memRe    = !bus.cpu_we;
      memWe    = bus.cpu_we;
      addrSel  = bus.cpu_addr;
      wdataSel = bus.cpu_wdata;
    end else if (dbgGnt) begin
      memRe    = !bus.dbg_we;
      memWe    = bus.dbg_we;
      addrSel  = bus.dbg_addr;
      wdataSel = bus.dbg_wdata;
    end
  end

  assign cpuRvalid = rdValid_q && (rdOwner_q == PORT_CPU);
  assign dbgRvalid = rdValid_q && (rdOwner_q == PORT_DBG);

  assign bus.cpu_gnt    = cpuGnt;
  assign bus.cpu_stall  = bus.cpu_req && !cpuGnt;
  assign bus.cpu_rvalid = cpuRvalid;
  assign bus.cpu_rdata  = cpuRvalid ? bus.mem_rdata : '0;
  assign bus.dbg_gnt    = dbgGnt;
  assign bus.dbg_rvalid = dbgRvalid;
  assign bus.dbg_rdata  = dbgRvalid ? bus.mem_rdata : '0;
  assign bus.dbg_locked = (owner_q == OWN_LOCKED);
  assign bus.mem_re     = memRe;
  assign bus.mem_we     = memWe;
  assign bus.mem_addr   = addrSel;
  assign bus.mem_wdata  = wdataSel;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset/lock corner sequences,
// then random traffic checked against a cycle-level behavioural model.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [7:0] Z = 8'h00;

  typedef struct {
    logic       cReq, cWe;
    logic [7:0] cAddr, cWdata;
    logic       dReq, dWe;
    logic [7:0] dAddr, dWdata;
    logic       dLock;
  } stim_t;

  typedef struct {
    logic       cGnt, dGnt, cStall, cRv;
    logic [7:0] cRd;
    logic       dRv;
    logic [7:0] dRd;
    logic       locked;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic clock;
  logic reset;
  logic loadMem;
  int   total;
  int   bad;

  logic [7:0] memArr [256];
  logic [7:0] memRd;
  logic [7:0] refMem [256];
  vec_t       vecs [$];

  mem_port_arbiter_if #(.AW(8), .DW(8)) bus ();

  mem_port_arbiter #(
    .AW           (8),
    .DW           (8),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // memory behind the arbiter: synchronous read, data one cycle after mem_re
  always @(posedge clock) begin
    if (loadMem) begin
      for (int i = 0; i < 256; i++) memArr[i] <= 8'(i + 'h4A);
      memRd <= '0;
    end else begin
      if (bus.mem_we) memArr[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_re) memRd <= memArr[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = memRd;

  function automatic vec_t mk(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                              input logic dr, input logic dw, input logic [7:0] da, input logic [7:0] dd,
                              input logic dl, input logic cg, input logic dg, input logic cs,
                              input logic crv, input logic [7:0] crd, input logic drv, input logic [7:0] drd,
                              input logic lk);
    vec_t v;
    v.s = '{cr, cw, ca, cd, dr, dw, da, dd, dl};
    v.e = '{cg, dg, cs, crv, crd, drv, drd, lk};
    return v;
  endfunction

  task automatic applyStimulus(input stim_t s);
    bus.cpu_req   = s.cReq;
    bus.cpu_we    = s.cWe;
    bus.cpu_addr  = s.cAddr;
    bus.cpu_wdata = s.cWdata;
    bus.dbg_req   = s.dReq;
    bus.dbg_we    = s.dWe;
    bus.dbg_addr  = s.dAddr;
    bus.dbg_wdata = s.dWdata;
    bus.dbg_lock  = s.dLock;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic checkCycle(input string tag, input exp_t e, input stim_t s);
    logic       mre, mwe;
    logic [7:0] ma, mw;
    mre = 1'b0; mwe = 1'b0; ma = '0; mw = '0;
    if (e.cGnt) begin
      mre = !s.cWe; mwe = s.cWe; ma = s.cAddr; mw = s.cWdata;
    end else if (e.dGnt) begin
      mre = !s.dWe; mwe = s.dWe; ma = s.dAddr; mw = s.dWdata;
    end
    checkOutput({tag, " cpu_gnt"},    32'(bus.cpu_gnt),    32'(e.cGnt));
    checkOutput({tag, " dbg_gnt"},    32'(bus.dbg_gnt),    32'(e.dGnt));
    checkOutput({tag, " cpu_stall"},  32'(bus.cpu_stall),  32'(e.cStall));
    checkOutput({tag, " cpu_rvalid"}, 32'(bus.cpu_rvalid), 32'(e.cRv));
    checkOutput({tag, " cpu_rdata"},  32'(bus.cpu_rdata),  32'(e.cRd));
    checkOutput({tag, " dbg_rvalid"}, 32'(bus.dbg_rvalid), 32'(e.dRv));
    checkOutput({tag, " dbg_rdata"},  32'(bus.dbg_rdata),  32'(e.dRd));
    checkOutput({tag, " dbg_locked"}, 32'(bus.dbg_locked), 32'(e.locked));
    checkOutput({tag, " mem_re"},     32'(bus.mem_re),     32'(mre));
    checkOutput({tag, " mem_we"},     32'(bus.mem_we),     32'(mwe));
    checkOutput({tag, " mem_addr"},   32'(bus.mem_addr),   32'(ma));
    checkOutput({tag, " mem_wdata"},  32'(bus.mem_wdata),  32'(mw));
  endtask

  task automatic resetAll();
    stim_t idle;
    idle = '{L, L, Z, Z, L, L, Z, Z, L};
    applyStimulus(idle);
    loadMem = 1'b1;
    reset   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset   = 1'b1;
    loadMem = 1'b0;
  endtask

  initial begin
    stim_t s;
    exp_t  e;
    logic  cHold, dHold, mLocked, mPend, mPendPort;
    logic [7:0] mPendData;
    int    mStreak;

    total = 0;
    bad   = 0;
    reset = 1'b0;
    loadMem = 1'b1;

    vecs.push_back(mk(L,L,Z,Z,       L,L,Z,Z,L,             L,L,L,L,Z,L,Z,L));
    vecs.push_back(mk(H,L,8'h10,Z,   L,L,Z,Z,L,             H,L,L,L,Z,L,Z,L));
    vecs.push_back(mk(L,L,Z,Z,       L,L,Z,Z,L,             L,L,L,H,8'h5A,L,Z,L));
    vecs.push_back(mk(H,L,8'h01,Z,   H,L,8'h02,Z,L,         H,L,L,L,Z,L,Z,L));
    vecs.push_back(mk(H,L,8'h01,Z,   H,L,8'h02,Z,L,         H,L,L,H,8'h4B,L,Z,L));
    vecs.push_back(mk(H,L,8'h01,Z,   H,L,8'h02,Z,L,         H,L,L,H,8'h4B,L,Z,L));
    vecs.push_back(mk(H,L,8'h01,Z,   H,L,8'h02,Z,L,         H,L,L,H,8'h4B,L,Z,L));
    vecs.push_back(mk(H,L,8'h01,Z,   H,L,8'h02,Z,L,         L,H,H,H,8'h4B,L,Z,L));
    vecs.push_back(mk(H,L,8'h01,Z,   L,L,Z,Z,L,             H,L,L,L,Z,H,8'h4C,L));
    vecs.push_back(mk(L,L,Z,Z,       H,L,8'h02,Z,L,         L,H,L,H,8'h4B,L,Z,L));
    vecs.push_back(mk(H,L,8'h01,Z,   L,L,Z,Z,L,             H,L,L,L,Z,H,8'h4C,L));
    vecs.push_back(mk(L,L,Z,Z,       L,L,Z,Z,L,             L,L,L,H,8'h4B,L,Z,L));
    vecs.push_back(mk(L,L,Z,Z,       H,H,8'h20,8'h33,H,     L,H,L,L,Z,L,Z,L));
    vecs.push_back(mk(H,L,8'h20,Z,   L,L,Z,Z,H,             L,L,H,L,Z,L,Z,H));
    vecs.push_back(mk(H,L,8'h20,Z,   L,L,Z,Z,H,             L,L,H,L,Z,L,Z,H));
    vecs.push_back(mk(H,L,8'h20,Z,   L,L,Z,Z,L,             L,L,H,L,Z,L,Z,H));
    vecs.push_back(mk(H,L,8'h20,Z,   L,L,Z,Z,L,             H,L,L,L,Z,L,Z,L));
    vecs.push_back(mk(L,L,Z,Z,       L,L,Z,Z,L,             L,L,L,H,8'h33,L,Z,L));
    vecs.push_back(mk(H,L,8'h10,Z,   H,H,8'h30,8'h44,H,     H,L,L,L,Z,L,Z,L));
    vecs.push_back(mk(L,L,Z,Z,       H,H,8'h30,8'h44,H,     L,H,L,H,8'h5A,L,Z,L));
    vecs.push_back(mk(H,L,8'h10,Z,   L,L,Z,Z,L,             L,L,H,L,Z,L,Z,H));
    vecs.push_back(mk(H,L,8'h10,Z,   L,L,Z,Z,L,             H,L,L,L,Z,L,Z,L));
    vecs.push_back(mk(L,L,Z,Z,       L,L,Z,Z,L,             L,L,L,H,8'h5A,L,Z,L));
    vecs.push_back(mk(L,L,Z,Z,       L,L,Z,Z,H,             L,L,L,L,Z,L,Z,L));
    vecs.push_back(mk(H,L,8'h02,Z,   L,L,Z,Z,H,             H,L,L,L,Z,L,Z,L));
    vecs.push_back(mk(L,L,Z,Z,       L,L,Z,Z,L,             L,L,L,H,8'h4C,L,Z,L));
    vecs.push_back(mk(L,L,Z,Z,       H,L,8'h30,Z,L,         L,H,L,L,Z,L,Z,L));
    vecs.push_back(mk(L,L,Z,Z,       L,L,Z,Z,L,             L,L,L,L,Z,H,8'h44,L));

    resetAll();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].s);
      @(negedge clock);
      checkCycle($sformatf("vec%0d", i), vecs[i].e, vecs[i].s);
      @(posedge clock);
      #1;
    end

    // starvation count built up before reset must not survive it
    s = '{H, L, 8'h01, Z, H, L, 8'h02, Z, L};
    applyStimulus(s);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkOutput($sformatf("pre-reset win%0d cpu_gnt", k), 32'(bus.cpu_gnt), 32'd1);
      @(posedge clock);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    checkOutput("in-reset cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    checkOutput("in-reset dbg_locked", 32'(bus.dbg_locked), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("release cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    checkOutput("release cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock);
      #1;
      @(negedge clock);
      checkOutput($sformatf("post-reset c%0d cpu_gnt", k), 32'(bus.cpu_gnt), 32'(k < 4));
      checkOutput($sformatf("post-reset c%0d dbg_gnt", k), 32'(bus.dbg_gnt), 32'(k == 4));
      checkOutput($sformatf("post-reset c%0d cpu_stall", k), 32'(bus.cpu_stall), 32'(k == 4));
      checkOutput($sformatf("post-reset c%0d cpu_rdata", k), 32'(bus.cpu_rdata), 32'h4B);
    end
    @(posedge clock);
    #1;
    applyStimulus('{L, L, Z, Z, L, L, Z, Z, L});
    @(negedge clock);
    checkOutput("post-starve dbg_rdata", 32'(bus.dbg_rdata), 32'h4C);
    @(posedge clock);
    #1;

    // reset while locked with a DBG read in flight
    applyStimulus('{L, L, Z, Z, H, L, 8'h02, Z, H});
    @(negedge clock);
    checkOutput("lock-seq dbg_gnt", 32'(bus.dbg_gnt), 32'd1);
    @(posedge clock);
    #1;
    applyStimulus('{L, L, Z, Z, H, L, 8'h01, Z, H});
    @(negedge clock);
    checkOutput("lock-seq dbg_locked", 32'(bus.dbg_locked), 32'd1);
    @(posedge clock);
    #1;
    applyStimulus('{H, L, 8'h10, Z, L, L, Z, Z, H});
    #2;
    reset = 1'b0;
    #1;
    checkOutput("lock-reset dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
    checkOutput("lock-reset dbg_locked", 32'(bus.dbg_locked), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("lock-release cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    checkOutput("lock-release dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
    @(posedge clock);
    #1;
    applyStimulus('{L, L, Z, Z, L, L, Z, Z, L});
    @(negedge clock);
    checkOutput("lock-release cpu_rdata", 32'(bus.cpu_rdata), 32'h5A);
    checkOutput("lock-release dbg_rvalid2", 32'(bus.dbg_rvalid), 32'd0);
    checkOutput("lock-release dbg_locked", 32'(bus.dbg_locked), 32'd0);
    @(posedge clock);
    #1;

    // random traffic against the behavioural model
    resetAll();
    for (int i = 0; i < 256; i++) refMem[i] = 8'(i + 'h4A);
    mLocked = 1'b0; mPend = 1'b0; mPendPort = 1'b0; mPendData = '0; mStreak = 0;
    cHold = 1'b0; dHold = 1'b0;
    s = '{L, L, Z, Z, L, L, Z, Z, L};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!cHold) begin
        s.cReq = ($urandom_range(0, 99) < 65);
        s.cWe = ($urandom_range(0, 3) == 0);
        s.cAddr = 8'($urandom_range(0, 15));
        s.cWdata = 8'($urandom);
      end
      if (!dHold) begin
        s.dReq = ($urandom_range(0, 99) < 55);
        s.dWe = ($urandom_range(0, 3) == 0);
        s.dAddr = 8'($urandom_range(0, 15));
        s.dWdata = 8'($urandom);
      end
      s.dLock = ($urandom_range(0, 99) < 35);

      if (mLocked) begin
        e.cGnt = 1'b0;
        e.dGnt = s.dReq;
      end else if (s.cReq && s.dReq) begin
        e.dGnt = (mStreak >= LIMIT);
        e.cGnt = !e.dGnt;
      end else begin
        e.cGnt = s.cReq;
        e.dGnt = s.dReq;
      end
      e.cStall = s.cReq && !e.cGnt;
      e.cRv    = mPend && (mPendPort == 1'b0);
      e.cRd    = e.cRv ? mPendData : 8'h00;
      e.dRv    = mPend && (mPendPort == 1'b1);
      e.dRd    = e.dRv ? mPendData : 8'h00;
      e.locked = mLocked;

      applyStimulus(s);
      @(negedge clock);
      checkCycle($sformatf("rnd%0d", cyc), e, s);

      mPend = 1'b0;
      if (e.cGnt) begin
        if (s.cWe) refMem[s.cAddr] = s.cWdata;
        else begin mPend = 1'b1; mPendPort = 1'b0; mPendData = refMem[s.cAddr]; end
      end
      if (e.dGnt) begin
        if (s.dWe) refMem[s.dAddr] = s.dWdata;
        else begin mPend = 1'b1; mPendPort = 1'b1; mPendData = refMem[s.dAddr]; end
      end
      if (s.dReq && e.cGnt) mStreak = (mStreak < LIMIT) ? mStreak + 1 : LIMIT;
      else mStreak = 0;
      if (!mLocked && e.dGnt && s.dLock) mLocked = 1'b1;
      else if (mLocked && !s.dLock) mLocked = 1'b0;
      cHold = s.cReq && !e.cGnt;
      dHold = s.dReq && !e.dGnt;

      @(posedge clock);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
